// File: rtl/wb_aperture_ctrl_if.sv
// Wishbone bundle between the AHB bridge, the aperture controller and its two register clients.
// The slave modport is the controller's view; master is the bridge/client side.
interface wb_aperture_ctrl_if #(
  parameter int unsigned APERWIDTH = 17
);
  logic [APERWIDTH-1:0] WBs_ADR;
  logic                 WBs_CYC;
  logic                 WBs_STB;
  logic                 WBs_CYC_S0;
  logic                 WBs_CYC_S1;
  logic                 WBs_ACK_S0;
  logic                 WBs_ACK_S1;
  logic [31:0]          WBs_RD_DAT_S0;
  logic [31:0]          WBs_RD_DAT_S1;
  logic                 WBs_ACK;
  logic [31:0]          WBs_RD_DAT;

  modport slave (
    input  WBs_ADR, WBs_CYC, WBs_STB, WBs_ACK_S0, WBs_ACK_S1, WBs_RD_DAT_S0, WBs_RD_DAT_S1,
    output WBs_CYC_S0, WBs_CYC_S1, WBs_ACK, WBs_RD_DAT
  );

  modport master (
    output WBs_ADR, WBs_CYC, WBs_STB, WBs_ACK_S0, WBs_ACK_S1, WBs_RD_DAT_S0, WBs_RD_DAT_S1,
    input  WBs_CYC_S0, WBs_CYC_S1, WBs_ACK, WBs_RD_DAT
  );
endinterface

// File: rtl/wb_aperture_ctrl.sv
// Wishbone aperture controller: decodes the bridge address onto one of two register clients,
// muxes their ack/data back, and supplies a default ack plus sticky error on client timeout.
module wb_aperture_ctrl #(
  parameter int unsigned          APERWIDTH            = 17,
  parameter int unsigned          APERSIZE             = 9,
  parameter logic [APERWIDTH-1:0] SLAVE0_BASE_ADDRESS  = 17'h00000,
  parameter logic [APERWIDTH-1:0] SLAVE1_BASE_ADDRESS  = 17'h00800,
  parameter logic [31:0]          DEFAULT_READ_VALUE   = 32'hBAD_FAB_AC,
  parameter int unsigned          DEFAULT_CNTR_WIDTH   = 3,
  parameter int unsigned          DEFAULT_CNTR_TIMEOUT = 7
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  wb_aperture_ctrl_if.slave bus,
  input  logic              Err_Clr,
  output logic              Timeout_Err,
  output logic              Bus_Busy
);

  localparam int unsigned WinShift = APERSIZE + 2;
  localparam logic [DEFAULT_CNTR_WIDTH-1:0] TimeoutCnt =
      DEFAULT_CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [1:0] {SelNone, Sel0, Sel1} sel_e;

  state_e                        r_state, w_state_nxt;
  sel_e                          r_sel, w_sel_nxt;
  logic [DEFAULT_CNTR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                          r_err, w_err_nxt;

  logic        w_hit0, w_hit1, w_sel_ack, w_set_err;
  logic        w_ack, w_cyc_s0, w_cyc_s1, w_busy;
  logic [31:0] w_rd_dat;

  // Only the bits above the window size take part in the decode.
  assign w_hit0 = (bus.WBs_ADR >> WinShift) == (SLAVE0_BASE_ADDRESS >> WinShift);
  assign w_hit1 = (bus.WBs_ADR >> WinShift) == (SLAVE1_BASE_ADDRESS >> WinShift);

  assign w_sel_ack = ((r_sel == Sel0) && bus.WBs_ACK_S0) || ((r_sel == Sel1) && bus.WBs_ACK_S1);

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_state <= StIdle;
      r_sel   <= SelNone;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_set_err   = 1'b0;
    w_ack       = 1'b0;
    w_rd_dat    = '0;
    w_cyc_s0    = 1'b0;
    w_cyc_s1    = 1'b0;
    w_busy      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.WBs_CYC && bus.WBs_STB) begin
          w_sel_nxt   = w_hit0 ? Sel0 : (w_hit1 ? Sel1 : SelNone);
          w_cnt_nxt   = '0;
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        w_busy   = 1'b1;
        w_cyc_s0 = bus.WBs_CYC && (r_sel == Sel0);
        w_cyc_s1 = bus.WBs_CYC && (r_sel == Sel1);
        // A dropped cycle is an abort: no ack, no error.
        if (!bus.WBs_CYC) begin
          w_state_nxt = StIdle;
        end else if (w_sel_ack) begin
          w_ack       = 1'b1;
          w_rd_dat    = (r_sel == Sel0) ? bus.WBs_RD_DAT_S0 : bus.WBs_RD_DAT_S1;
          w_state_nxt = StDone;
        end else if (r_cnt == TimeoutCnt) begin
          w_ack       = 1'b1;
          w_rd_dat    = DEFAULT_READ_VALUE;
          w_set_err   = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_err_nxt = w_set_err ? 1'b1 : (Err_Clr ? 1'b0 : r_err);
  end

  assign bus.WBs_ACK    = w_ack && !WB_RST;
  assign bus.WBs_RD_DAT = WB_RST ? 32'h0 : w_rd_dat;
  assign bus.WBs_CYC_S0 = w_cyc_s0 && !WB_RST;
  assign bus.WBs_CYC_S1 = w_cyc_s1 && !WB_RST;
  assign Bus_Busy       = w_busy && !WB_RST;
  assign Timeout_Err    = r_err;

endmodule

// File: doc/wb_aperture_ctrl.md
Name: wb_aperture_ctrl

Overview:
- Wishbone transaction controller between the AHB-to-FPGA bridge outputs and two register-block clients.
- Client 0 is the FPGA register block; client 1 is the QL-reserved block.
- Decodes the aperture address and gates the cycle strobe to exactly one client.
- Muxes read data and acknowledge back to the bridge, and generates a default acknowledge with a sticky error flag when no client responds within a timeout, so the bridge never hangs.

Parameters:
APERWIDTH, 17, Wishbone address width.
APERSIZE, 9, client window size exponent; decode compares WBs_ADR[APERWIDTH-1:APERSIZE+2].
SLAVE0_BASE_ADDRESS, 17'h00000, client 0 window base.
SLAVE1_BASE_ADDRESS, 17'h00800, client 1 window base.
DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on timeout acknowledge.
DEFAULT_CNTR_WIDTH, 3, timeout counter width.
DEFAULT_CNTR_TIMEOUT, 7, wait cycles before default acknowledge; must be ≤ 2^DEFAULT_CNTR_WIDTH-1.

Ports:
WB_CLK  in  1  single clock for all logic.
WB_RST  in  1  reset; synchronous, active-high.
WBs_ADR  in  17  address from bridge.
WBs_CYC  in  1  cycle from bridge.
WBs_STB  in  1  strobe from bridge.
WBs_CYC_S0  out  1  cycle to client 0.
WBs_CYC_S1  out  1  cycle to client 1.
WBs_ACK_S0  in  1  acknowledge from client 0.
WBs_ACK_S1  in  1  acknowledge from client 1.
WBs_RD_DAT_S0  in  32  read data from client 0.
WBs_RD_DAT_S1  in  32  read data from client 1.
WBs_ACK  out  1  acknowledge to bridge.
WBs_RD_DAT  out  32  read data to bridge.
Timeout_Err  out  1  sticky flag: a default acknowledge occurred.
Err_Clr  in  1  clears Timeout_Err.
Bus_Busy  out  1  high while the FSM is in BUSY.

Behaviour:
- Reset: the FSM enters IDLE, the counter clears to 0, and Timeout_Err clears to 0.
- Under reset, all outputs are 0: WBs_ACK, WBs_RD_DAT, WBs_CYC_S0/S1 and Bus_Busy.
- Decode is combinational. hit0 is true when the compared address bits equal the same bits of SLAVE0_BASE_ADDRESS; hit1 likewise for SLAVE1_BASE_ADDRESS. hit0 takes priority if both match.
- The selection is latched on entry to BUSY and held for the whole transaction.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - WBs_CYC_Sx=0, WBs_ACK=0, WBs_RD_DAT=0.
  - If WBs_CYC & WBs_STB: latch sel (0, 1 or none), clear the counter, go to BUSY.
- BUSY:
  - Bus_Busy=1. WBs_CYC_Sx = WBs_CYC & (sel==x), combinational.
  - If the selected client's ACK is 1: WBs_ACK=1 and WBs_RD_DAT = that client's data in the same cycle (zero added latency); go to DONE.
  - Else if counter == DEFAULT_CNTR_TIMEOUT: WBs_ACK=1, WBs_RD_DAT=DEFAULT_READ_VALUE, set Timeout_Err; go to DONE.
  - Else: counter+1.
  - ACK from the non-selected client is ignored.
  - Unmapped address (sel none): no client cycle is asserted, and the default acknowledge follows the normal timeout.
- DONE: one cycle with all strobes and ACK at 0, then IDLE. This gives the bridge a cycle to drop STB; a back-to-back request is accepted in the following IDLE cycle.
- Timeout latency: STB seen in IDLE at cycle t → first BUSY at t+1 (counter 0) → default ACK at t+1+DEFAULT_CNTR_TIMEOUT (t+8 at defaults).
- Simultaneous client ACK and counter==TIMEOUT: the client ACK wins, client data is returned, and no error is flagged.
- WBs_CYC dropped during BUSY (abort): return to IDLE next cycle, no ACK, no error.
- Timeout_Err with Err_Clr and a timeout in the same cycle: the set wins.
- WBs_ACK is high for exactly one cycle per transaction.
- WBs_RD_DAT is 0 whenever WBs_ACK=0.
- WB_RST asserted mid-transaction: IDLE on the next edge, all outputs 0, and the pending transaction is dropped without ACK.

Test Plan:
- Read 17'h00004, client 0 acks on the 3rd BUSY cycle with 32'h12345678 → WBs_CYC_S0=1 for 3 cycles, WBs_CYC_S1=0, and WBs_ACK=1 for one cycle with 32'h12345678; Timeout_Err stays 0.
- Read 17'h00800, client 1 acks immediately with 32'h01000001 → ACK in the first BUSY cycle (STB+1), data passed through, DONE, IDLE.
- Read 17'h01000 (unmapped), defaults → no client cycle; ACK with 32'hBAD_FAB_AC exactly 8 cycles after STB is sampled; Timeout_Err=1, and it stays 1 until Err_Clr pulses.
- Client 0 silent, then acks in the same cycle the counter reaches 7 → client data returned, Timeout_Err=0; client 1 acking during a client 0 transaction has no effect.
- WBs_CYC dropped on the 2nd BUSY cycle → no ACK, IDLE next cycle. WB_RST pulsed mid-BUSY → all outputs 0 next edge; the next read completes normally.
- Back-to-back reads with STB held → one ACK per transaction, separated by the DONE and IDLE cycles; Err_Clr coinciding with a timeout leaves Timeout_Err=1.
